cpu_axi_master: RTL and testbench

CPU_AXI_MASTER -- requirements
Module: cpu_axi_master

---
 rtl/cpu_axi_master_pkg.sv | 28 ++
 rtl/cpu_axi_master_if.sv | 65 ++++++
 rtl/cpu_axi_master.sv | 161 ++++++++++++++++
 tb/tb_cpu_axi_master.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_master_pkg.sv
// Shared AXI widths, encodings and FSM state codes for the CPU-side AXI master.
package cpu_axi_master_pkg;

    localparam int AXI_ID_W    = 4;
    localparam int AXI_IDS_W   = 8;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_STRB_W  = 4;
    localparam int AXI_LEN_W   = 4;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_RESP_W-1:0]  AXI_RESP_OKAY  = 2'b00;
    localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [AXI_SIZE_W-1:0]  AXI_SIZE_WORD  = 3'b010;
    localparam logic [AXI_LEN_W-1:0]   AXI_LEN_SINGLE = 4'd0;

    // Master FSM state set, kept as plain constants for legacy tool flows.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RADDR = 3'd1;
    localparam state_t ST_RDATA = 3'd2;
    localparam state_t ST_WRITE = 3'd3;
    localparam state_t ST_WRESP = 3'd4;
    localparam state_t ST_DONE  = 3'd5;

endpackage

// File: rtl/cpu_axi_master_if.sv
// AXI4 channel bundle between one CPU-side master and the interconnect.
interface cpu_axi_master_if;
    import cpu_axi_master_pkg::*;

    logic [AXI_ID_W-1:0]    ARID_M;
    logic [AXI_ADDR_W-1:0]  ARADDR_M;
    logic [AXI_LEN_W-1:0]   ARLEN_M;
    logic [AXI_SIZE_W-1:0]  ARSIZE_M;
    logic [AXI_BURST_W-1:0] ARBURST_M;
    logic                   ARVALID_M;
    logic                   ARREADY_M;

    logic [AXI_IDS_W-1:0]   RID_M;
    logic [AXI_DATA_W-1:0]  RDATA_M;
    logic [AXI_RESP_W-1:0]  RRESP_M;
    logic                   RLAST_M;
    logic                   RVALID_M;
    logic                   RREADY_M;

    logic [AXI_ID_W-1:0]    AWID_M;
    logic [AXI_ADDR_W-1:0]  AWADDR_M;
    logic [AXI_LEN_W-1:0]   AWLEN_M;
    logic [AXI_SIZE_W-1:0]  AWSIZE_M;
    logic [AXI_BURST_W-1:0] AWBURST_M;
    logic                   AWVALID_M;
    logic                   AWREADY_M;

    logic [AXI_DATA_W-1:0]  WDATA_M;
    logic [AXI_STRB_W-1:0]  WSTRB_M;
    logic                   WLAST_M;
    logic                   WVALID_M;
    logic                   WREADY_M;

    logic [AXI_IDS_W-1:0]   BID_M;
    logic [AXI_RESP_W-1:0]  BRESP_M;
    logic                   BVALID_M;
    logic                   BREADY_M;

    modport master (
        output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        input  ARREADY_M,
        input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        output RREADY_M,
        output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        input  AWREADY_M,
        output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        input  WREADY_M,
        input  BID_M, BRESP_M, BVALID_M,
        output BREADY_M
    );

    modport slave (
        input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
        output ARREADY_M,
        output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
        input  RREADY_M,
        input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
        output AWREADY_M,
        input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
        output WREADY_M,
        output BID_M, BRESP_M, BVALID_M,
        input  BREADY_M
    );

endinterface

// File: rtl/cpu_axi_master.sv
// Bridges a stalling CPU memory port onto AXI4 with one single-beat transaction at a time.
// Used once for the instruction port and once for the data port, each with its own MASTER_ID.
module cpu_axi_master
    import cpu_axi_master_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] MASTER_ID = 4'd0
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [AXI_ADDR_W-1:0]  addr_i,
    input  logic [AXI_DATA_W-1:0]  wdata_i,
    input  logic [AXI_STRB_W-1:0]  wstrb_i,
    output logic [AXI_DATA_W-1:0]  rdata_o,
    output logic                   stall_o,
    output logic                   err_o,
    cpu_axi_master_if.master       axi
);

    state_t                  state_q,   state_d;
    logic [AXI_ADDR_W-1:0]   addr_q,    addr_d;
    logic [AXI_DATA_W-1:0]   wdata_q,   wdata_d;
    logic [AXI_STRB_W-1:0]   wstrb_q,   wstrb_d;
    logic                    we_q,      we_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q,  w_done_d;
    logic [AXI_RESP_W-1:0]   resp_q,    resp_d;
    logic [AXI_DATA_W-1:0]   rdata_q,   rdata_d;

    logic ar_valid, r_ready, aw_valid, w_valid, b_ready;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;

    // Each VALID is a pure function of registered state, so it cannot drop before its READY.
    assign ar_valid = (state_q == ST_RADDR);
    assign r_ready  = (state_q == ST_RDATA);
    assign aw_valid = (state_q == ST_WRITE) && !aw_done_q;
    assign w_valid  = (state_q == ST_WRITE) && !w_done_q;
    assign b_ready  = (state_q == ST_WRESP);

    assign ar_hs = ar_valid && axi.ARREADY_M;
    assign r_hs  = r_ready  && axi.RVALID_M;
    assign aw_hs = aw_valid && axi.AWREADY_M;
    assign w_hs  = w_valid  && axi.WREADY_M;
    assign b_hs  = b_ready  && axi.BVALID_M;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        we_d      = we_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (req_i) begin
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    wstrb_d = wstrb_i;
                    we_d    = we_i;
                    state_d = we_i ? ST_WRITE : ST_RADDR;
                end
            end
            ST_RADDR: begin
                if (ar_hs) begin
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                // Non-final beats are accepted and dropped; only the RLAST beat completes.
                if (r_hs && axi.RLAST_M) begin
                    resp_d  = axi.RRESP_M;
                    if (!we_q) begin
                        rdata_d = axi.RDATA_M;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                aw_done_d = aw_done_q || aw_hs;
                w_done_d  = w_done_q  || w_hs;
                if (aw_done_d && w_done_d) begin
                    state_d = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (b_hs) begin
                    resp_d  = axi.BRESP_M;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (ARESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            we_q      <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            resp_q    <= AXI_RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            we_q      <= we_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axi.ARID_M    = MASTER_ID;
    assign axi.ARADDR_M  = addr_q;
    assign axi.ARLEN_M   = AXI_LEN_SINGLE;
    assign axi.ARSIZE_M  = AXI_SIZE_WORD;
    assign axi.ARBURST_M = AXI_BURST_INCR;
    assign axi.ARVALID_M = ar_valid;
    assign axi.RREADY_M  = r_ready;

    assign axi.AWID_M    = MASTER_ID;
    assign axi.AWADDR_M  = addr_q;
    assign axi.AWLEN_M   = AXI_LEN_SINGLE;
    assign axi.AWSIZE_M  = AXI_SIZE_WORD;
    assign axi.AWBURST_M = AXI_BURST_INCR;
    assign axi.AWVALID_M = aw_valid;
    assign axi.WDATA_M   = wdata_q;
    assign axi.WSTRB_M   = wstrb_q;
    assign axi.WLAST_M   = 1'b1;
    assign axi.WVALID_M  = w_valid;
    assign axi.BREADY_M  = b_ready;

    // Response IDs are ignored: every response on this port belongs to this master.
    logic unused_resp_ids;
    assign unused_resp_ids = ^{axi.RID_M, axi.BID_M};

    assign stall_o = (state_q == ST_IDLE) ? req_i : (state_q != ST_DONE);
    assign err_o   = (state_q == ST_DONE) && (resp_q != AXI_RESP_OKAY);
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed and randomized bench for cpu_axi_master against a transaction-level obligation model.
module tb_cpu_axi_master;

    localparam logic [3:0] MID = 4'hA;

    logic        ACLK;
    logic        ARESET;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  wstrb_i;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic        err_o;

    cpu_axi_master_if bus ();

    cpu_axi_master #(.MASTER_ID(MID)) dut (
        .ACLK    (ACLK),
        .ARESET  (ARESET),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .wstrb_i (wstrb_i),
        .rdata_o (rdata_o),
        .stall_o (stall_o),
        .err_o   (err_o),
        .axi     (bus)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic sample();
        @(negedge ACLK);
    endtask

    // Model: what the master still owes the bus for the transaction in flight.
    logic        m_valid = 1'b0;
    logic        m_busy, m_done, m_ar, m_r, m_aw, m_w, m_b;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_resp;
    logic        core_complete = 1'b0;

    initial begin
        logic exp_stall, exp_err;
        forever begin
            @(negedge ACLK);
            if (m_valid) begin
                exp_stall = m_done ? 1'b0 : (m_busy ? 1'b1 : req_i);
                exp_err   = m_done && (m_resp != 2'b00);
                check("stall_o", 32'(stall_o), 32'(exp_stall));
                check("err_o", 32'(err_o), 32'(exp_err));
                check("rdata_o", rdata_o, m_rdata);
                check("ARVALID", 32'(bus.ARVALID_M), 32'(m_ar));
                check("RREADY", 32'(bus.RREADY_M), 32'(m_r));
                check("AWVALID", 32'(bus.AWVALID_M), 32'(m_aw));
                check("WVALID", 32'(bus.WVALID_M), 32'(m_w));
                check("BREADY", 32'(bus.BREADY_M), 32'(m_b));
                if (m_ar) begin
                    check("ARADDR", bus.ARADDR_M, m_addr);
                    check("AR_id_len_size_burst",
                          {19'd0, bus.ARID_M, bus.ARLEN_M, bus.ARSIZE_M, bus.ARBURST_M},
                          {19'd0, MID, 4'd0, 3'b010, 2'b01});
                end
                if (m_aw) begin
                    check("AWADDR", bus.AWADDR_M, m_addr);
                    check("AW_id_len_size_burst",
                          {19'd0, bus.AWID_M, bus.AWLEN_M, bus.AWSIZE_M, bus.AWBURST_M},
                          {19'd0, MID, 4'd0, 3'b010, 2'b01});
                end
                if (m_w) begin
                    check("WDATA", bus.WDATA_M, m_wdata);
                    check("WSTRB_WLAST", {27'd0, bus.WSTRB_M, bus.WLAST_M}, {27'd0, m_wstrb, 1'b1});
                end
            end
            core_complete = m_valid && m_done && req_i && !ARESET;
            if (ARESET) begin
                m_valid = 1'b1;
                {m_busy, m_done, m_ar, m_r, m_aw, m_w, m_b} = '0;
                m_addr = '0; m_wdata = '0; m_wstrb = '0; m_resp = '0; m_rdata = '0;
            end else if (m_valid) begin
                if (m_done) begin
                    m_done = 1'b0;
                    m_busy = 1'b0;
                end else if (!m_busy) begin
                    if (req_i) begin
                        m_busy  = 1'b1;
                        m_addr  = addr_i;
                        m_wdata = wdata_i;
                        m_wstrb = wstrb_i;
                        if (we_i) begin m_aw = 1'b1; m_w = 1'b1; end
                        else m_ar = 1'b1;
                    end
                end else if (m_ar) begin
                    if (bus.ARREADY_M) begin m_ar = 1'b0; m_r = 1'b1; end
                end else if (m_r) begin
                    if (bus.RVALID_M && bus.RLAST_M) begin
                        m_r = 1'b0; m_done = 1'b1;
                        m_resp = bus.RRESP_M; m_rdata = bus.RDATA_M;
                    end
                end else if (m_aw || m_w) begin
                    if (m_aw && bus.AWREADY_M) m_aw = 1'b0;
                    if (m_w && bus.WREADY_M) m_w = 1'b0;
                    if (!m_aw && !m_w) m_b = 1'b1;
                end else if (m_b) begin
                    if (bus.BVALID_M) begin
                        m_b = 1'b0; m_done = 1'b1; m_resp = bus.BRESP_M;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic core_active;
        ARESET = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; wstrb_i = '0;
        bus.ARREADY_M = 1'b0; bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0;
        bus.RID_M = '0; bus.RDATA_M = '0; bus.RRESP_M = '0; bus.RLAST_M = 1'b0; bus.RVALID_M = 1'b0;
        bus.BID_M = '0; bus.BRESP_M = '0; bus.BVALID_M = 1'b0;

        // Reset state
        tick(); tick(); tick();
        ARESET = 1'b0;
        sample();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_valids", {27'd0, bus.ARVALID_M, bus.RREADY_M, bus.AWVALID_M, bus.WVALID_M, bus.BREADY_M}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        // Read with immediate ARREADY / RVALID
        tick(); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0010; bus.ARREADY_M = 1'b1;
        sample(); check("rd_c0_stall", 32'(stall_o), 32'd1);
        tick(); sample();
        check("rd_c1_arvalid", 32'(bus.ARVALID_M), 32'd1);
        check("rd_c1_araddr", bus.ARADDR_M, 32'h10);
        check("rd_c1_arlen", 32'(bus.ARLEN_M), 32'd0);
        tick(); bus.ARREADY_M = 1'b0;
        bus.RVALID_M = 1'b1; bus.RLAST_M = 1'b1; bus.RDATA_M = 32'hDEAD_BEEF; bus.RRESP_M = 2'b00;
        sample(); check("rd_c2_rready", 32'(bus.RREADY_M), 32'd1);
        tick(); bus.RVALID_M = 1'b0;
        sample();
        check("rd_c3_stall", 32'(stall_o), 32'd0);
        check("rd_c3_rdata", rdata_o, 32'hDEAD_BEEF);
        check("rd_c3_err", 32'(err_o), 32'd0);
        tick(); req_i = 1'b0;

        // Write: W accepted in cycle 1, AW in cycle 3
        tick(); req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678; wstrb_i = 4'b0011;
        sample(); check("wr_c0_stall", 32'(stall_o), 32'd1);
        tick(); bus.WREADY_M = 1'b1;
        sample();
        check("wr_c1_wvalid", 32'(bus.WVALID_M), 32'd1);
        check("wr_c1_wdata", bus.WDATA_M, 32'h1234_5678);
        check("wr_c1_wstrb", 32'(bus.WSTRB_M), 32'h3);
        tick(); bus.WREADY_M = 1'b0;
        sample();
        check("wr_c2_wvalid", 32'(bus.WVALID_M), 32'd0);
        check("wr_c2_awvalid", 32'(bus.AWVALID_M), 32'd1);
        tick(); bus.AWREADY_M = 1'b1;
        sample();
        check("wr_c3_awvalid", 32'(bus.AWVALID_M), 32'd1);
        check("wr_c3_bready", 32'(bus.BREADY_M), 32'd0);
        tick(); bus.AWREADY_M = 1'b0; bus.BVALID_M = 1'b1; bus.BRESP_M = 2'b00;
        sample();
        check("wr_c4_bready", 32'(bus.BREADY_M), 32'd1);
        check("wr_c4_stall", 32'(stall_o), 32'd1);
        tick(); bus.BVALID_M = 1'b0;
        sample();
        check("wr_c5_stall", 32'(stall_o), 32'd0);
        check("wr_c5_rdata_held", rdata_o, 32'hDEAD_BEEF);
        tick(); req_i = 1'b0;

        // AR backpressure, then a discarded non-final beat
        tick(); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h40;
        for (int i = 0; i < 5; i++) begin
            tick(); sample();
            check("bp_arvalid", 32'(bus.ARVALID_M), 32'd1);
            check("bp_araddr", bus.ARADDR_M, 32'h40);
            check("bp_stall", 32'(stall_o), 32'd1);
        end
        tick(); bus.ARREADY_M = 1'b1;
        tick(); bus.ARREADY_M = 1'b0;
        bus.RVALID_M = 1'b1; bus.RLAST_M = 1'b0; bus.RDATA_M = 32'h1111_1111;
        tick(); bus.RLAST_M = 1'b1; bus.RDATA_M = 32'h2222_2222;
        sample(); check("bp_nonlast_stall", 32'(stall_o), 32'd1);
        tick(); bus.RVALID_M = 1'b0;
        sample();
        check("bp_done_stall", 32'(stall_o), 32'd0);
        check("bp_done_rdata", rdata_o, 32'h2222_2222);
        tick(); req_i = 1'b0;

        // SLVERR write response, simultaneous AW/W handshake
        tick(); req_i = 1'b1; we_i = 1'b1; addr_i = 32'h44; bus.AWREADY_M = 1'b1; bus.WREADY_M = 1'b1;
        tick(); sample();
        check("er_both_valid", {30'd0, bus.AWVALID_M, bus.WVALID_M}, 32'd3);
        tick(); bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0; bus.BVALID_M = 1'b1; bus.BRESP_M = 2'b10;
        sample(); check("er_wresp_err", 32'(err_o), 32'd0);
        tick(); bus.BVALID_M = 1'b0;
        sample();
        check("er_done_err", 32'(err_o), 32'd1);
        check("er_done_stall", 32'(stall_o), 32'd0);
        tick(); req_i = 1'b0;
        sample(); check("er_after_err", 32'(err_o), 32'd0);

        // Reset while waiting in the read data phase
        tick(); req_i = 1'b1; we_i = 1'b0; addr_i = 32'h50; bus.ARREADY_M = 1'b1;
        tick();
        tick(); bus.ARREADY_M = 1'b0; ARESET = 1'b1;
        sample(); check("rr_rready_before", 32'(bus.RREADY_M), 32'd1);
        tick(); ARESET = 1'b0; req_i = 1'b0;
        sample();
        check("rr_valids", {27'd0, bus.ARVALID_M, bus.RREADY_M, bus.AWVALID_M, bus.WVALID_M, bus.BREADY_M}, 32'd0);
        check("rr_stall_lo", 32'(stall_o), 32'd0);
        check("rr_rdata", rdata_o, 32'd0);

        // Back-to-back read then write with req_i held high
        tick(); req_i = 1'b1; addr_i = 32'h60; bus.ARREADY_M = 1'b1;
        sample(); check("rr_stall_hi", 32'(stall_o), 32'd1);
        tick();
        tick(); bus.ARREADY_M = 1'b0;
        bus.RVALID_M = 1'b1; bus.RLAST_M = 1'b1; bus.RDATA_M = 32'hA5A5_0001; bus.RRESP_M = 2'b00;
        tick(); bus.RVALID_M = 1'b0;
        sample(); check("bb_rd_done", 32'(stall_o), 32'd0);
        tick(); we_i = 1'b1; addr_i = 32'h64; wdata_i = 32'hBEEF_0002; wstrb_i = 4'hF;
        bus.AWREADY_M = 1'b1; bus.WREADY_M = 1'b1;
        sample(); check("bb_wr_start", 32'(stall_o), 32'd1);
        tick(); sample();
        check("bb_aw_w", {30'd0, bus.AWVALID_M, bus.WVALID_M}, 32'd3);
        check("bb_no_ar", 32'(bus.ARVALID_M), 32'd0);
        check("bb_awaddr", bus.AWADDR_M, 32'h64);
        tick(); bus.AWREADY_M = 1'b0; bus.WREADY_M = 1'b0; bus.BVALID_M = 1'b1; bus.BRESP_M = 2'b00;
        tick(); bus.BVALID_M = 1'b0;
        sample();
        check("bb_wr_done", 32'(stall_o), 32'd0);
        check("bb_rdata_held", rdata_o, 32'hA5A5_0001);
        tick(); req_i = 1'b0;

        // Randomized traffic checked by the model every cycle
        core_active = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (core_complete) core_active = 1'b0;
            ARESET = ($urandom_range(0, 249) == 0);
            if (!core_active && $urandom_range(0, 1) == 1) begin
                core_active = 1'b1;
                we_i    = 1'($urandom_range(0, 1));
                addr_i  = $urandom & 32'hFFFF_FFFC;
                wdata_i = $urandom;
                wstrb_i = 4'($urandom_range(0, 15));
            end
            req_i = core_active;
            bus.ARREADY_M = ($urandom_range(0, 2) != 0);
            bus.AWREADY_M = 1'($urandom_range(0, 1));
            bus.WREADY_M  = 1'($urandom_range(0, 1));
            bus.RID_M = 8'($urandom);
            bus.BID_M = 8'($urandom);
            bus.RDATA_M = $urandom;
            if (m_r && $urandom_range(0, 9) < 6) begin
                bus.RVALID_M = 1'b1;
                bus.RLAST_M  = ($urandom_range(0, 3) != 0);
                bus.RRESP_M  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                bus.RVALID_M = 1'b0;
                bus.RLAST_M  = 1'($urandom_range(0, 1));
            end
            if (m_b && $urandom_range(0, 9) < 6) begin
                bus.BVALID_M = 1'b1;
                bus.BRESP_M  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end else begin
                bus.BVALID_M = 1'b0;
            end
        end
        tick();
        ARESET = 1'b0; req_i = 1'b0; bus.RVALID_M = 1'b0; bus.BVALID_M = 1'b0;
        tick();
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
